spi_bridge: RTL

//  SPI slave front end (mode 0: CPOL=0, CPHA=0, MSB first), clocked entirely on the peripheral clock clk.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_bridge_if.sv | 35 +++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_bridge.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave bridge.
package spi_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_bridge_if.sv
// Pin and decoder-side signal bundle for spi_bridge.
// SPI_MISO_OE_EN adds the miso_oe pad-enable signal.
interface spi_bridge_if #(
    parameter int DATA_W = spi_pkg::DATA_W_DEF
);

    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              byte_sync;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] tx_data;
    logic              frame_err;
`ifdef SPI_MISO_OE_EN
    logic              miso_oe;
`endif

    modport slave (
        input  sclk, cs_n, mosi, tx_data,
        output miso, byte_sync, rx_data, frame_err
`ifdef SPI_MISO_OE_EN
        , output miso_oe
`endif
    );

    modport master (
        output sclk, cs_n, mosi, tx_data,
        input  miso, byte_sync, rx_data, frame_err
`ifdef SPI_MISO_OE_EN
        , input miso_oe
`endif
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async pin with rise/fall strobes
// taken from the last stage against a one-cycle delay flop.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~dly_q;
    assign fall_o  = ~level_o & dly_q;

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end, oversampled on clk. Optional macro
// SPI_MISO_OE_EN adds a registered miso_oe pad enable.
module spi_bridge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_bridge_if.slave  bus
);

    localparam int CNT_W    = $clog2(DATA_W);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(DATA_W - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(bus.sclk),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(bus.cs_n),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(bus.mosi),
        .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign sync_unused = ^{sclk_level, mosi_rise, mosi_fall};

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              boundary_q, boundary_d;
    logic              byte_sync_q, byte_sync_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_q, miso_d;
    logic              armed_q, armed_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic              last_bit;
`ifdef SPI_MISO_OE_EN
    logic              miso_oe_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SPI_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            boundary_q  <= 1'b0;
            byte_sync_q <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            armed_q     <= 1'b0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            boundary_q  <= boundary_d;
            byte_sync_q <= byte_sync_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            armed_q     <= armed_d;
            settle_q    <= settle_d;
        end
    end

    // A cs_n fall is only trusted once the synchronizer holds real pin
    // data and has shown cs_n high; this keeps a frame interrupted by
    // reset from being picked up halfway through.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        boundary_d  = boundary_q;
        byte_sync_d = 1'b0;
        frame_err_d = 1'b0;
        settle_d    = (settle_q == SETTLE_DONE) ? settle_q : settle_q + SETTLE_W'(1);
        armed_d     = armed_q | ((settle_q == SETTLE_DONE) & cs_level);
        last_bit    = 1'b0;

        case (state_q)
            SPI_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d    = SPI_ACTIVE;
                    bit_cnt_d  = '0;
                    tx_shift_d = bus.tx_data;
                    boundary_d = 1'b0;
                end
            end
            SPI_ACTIVE: begin
                last_bit = sclk_rise && (bit_cnt_q == LAST_BIT);
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_level};
                    if (last_bit) begin
                        bit_cnt_d   = '0;
                        rx_data_d   = rx_shift_d;
                        byte_sync_d = 1'b1;
                        boundary_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                if (sclk_fall) begin
                    if (boundary_q) begin
                        tx_shift_d = bus.tx_data;
                        boundary_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                // A byte finishing on the same clk as cs_n rise still counts.
                if (cs_rise) begin
                    state_d     = SPI_IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0) && !last_bit;
                end
            end
            default: state_d = SPI_IDLE;
        endcase

`ifdef SPI_MISO_OE_EN
        miso_d = tx_shift_q[DATA_W-1];
`else
        miso_d = (state_q == SPI_ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
`endif
    end

`ifdef SPI_MISO_OE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_oe_q <= 1'b0;
        end else begin
            miso_oe_q <= ~cs_level;
        end
    end

    assign bus.miso_oe = miso_oe_q;
`endif

    assign bus.miso      = miso_q;
    assign bus.byte_sync = byte_sync_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.frame_err = frame_err_q;

endmodule
